// File: rtl/fp_normalize_round.sv
// -----------------------------------------------------------------------------
// fp_normalize_round
// Post-adder stage of the FP32 add datapath. Takes the mantissa sum and
// carry-out from the CLA tree, normalizes it (one right shift on carry-out, or
// one left shift per cycle after cancellation), rounds to nearest-even and
// packs an IEEE-754 single. One operation in flight at a time.
//
// Parameters:
//   MANT_W  mantissa width including the hidden bit (default 24)
//   EXP_W   biased exponent width (default 8)
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid / in_ready         input handshake (ready only in IDLE)
//   in_sign, in_exp, in_sum,
//   in_cout, in_grs             operand from the alignment/adder stages
//   out_valid / out_ready       output handshake; result held until taken
//   out_result                  packed {sign, exp, frac}
//   out_overflow                result rounded to +/-inf
//   out_underflow               nonzero input gave a subnormal or zero result
//
// Configuration macro:
//   FP_NORM_FLUSH_DENORM_EN     when defined, subnormal results flush to
//                               signed zero (underflow still flagged)
// -----------------------------------------------------------------------------
module fp_normalize_round #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_sum,
  input  logic              in_cout,
  input  logic [2:0]        in_grs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_overflow,
  output logic              out_underflow
);

  localparam int                FRAC_W   = MANT_W - 1;
  // Exponent is carried one bit wider so a round-up past EXP_MAX is visible.
  localparam logic [EXP_W:0]    EXP_MAX  = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0]    EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [MANT_W-1:0] MANT_ONE = {1'b1, {FRAC_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSHIFT,
    S_LSHIFT,
    S_ROUND,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic              sign, sign_nx;
  logic [MANT_W-1:0] m, m_nx;
  logic [EXP_W:0]    e, e_nx;
  logic              g, g_nx, r, r_nx, s, s_nx;
  logic [31:0]       res_nx;
  logic              ovf_nx, unf_nx;

  logic              up;
  logic [MANT_W:0]   m_sum;
  logic [MANT_W-1:0] m_rnd;
  logic [EXP_W:0]    e_rnd, exp_fld, e_inc, e_dec;
  logic              rnd_ovf, rnd_unf;
  logic [31:0]       rnd_res, inf_res;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);

  assign e_inc   = e + EXP_ONE;
  assign e_dec   = e - EXP_ONE;
  assign inf_res = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};

  // Round-to-nearest-even on the current {m, g, r, s} and pack the result.
  always_comb begin
    up    = g & (r | s | m[0]);
    m_sum = {1'b0, m} + {{MANT_W{1'b0}}, up};
    if (m_sum[MANT_W]) begin
      m_rnd = MANT_ONE;
      e_rnd = e_inc;
    end else begin
      m_rnd = m_sum[MANT_W-1:0];
      e_rnd = e;
    end
    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
    exp_fld = (e_rnd == '0 && m_rnd[MANT_W-1]) ? EXP_ONE : e_rnd;
    rnd_ovf = (exp_fld >= EXP_MAX);
    rnd_unf = (exp_fld == '0);
    if (rnd_ovf) rnd_res = inf_res;
    else         rnd_res = {sign, exp_fld[EXP_W-1:0], m_rnd[FRAC_W-1:0]};
`ifdef FP_NORM_FLUSH_DENORM_EN
    if (rnd_unf && m_rnd[FRAC_W-1:0] != '0)
      rnd_res = {sign, {(EXP_W + FRAC_W){1'b0}}};
`else
`endif
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_nx = state;
    sign_nx  = sign;
    m_nx     = m;
    e_nx     = e;
    g_nx     = g;
    r_nx     = r;
    s_nx     = s;
    res_nx   = out_result;
    ovf_nx   = out_overflow;
    unf_nx   = out_underflow;

    unique case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          sign_nx = in_sign;
          m_nx    = in_sum;
          e_nx    = {1'b0, in_exp};
          {g_nx, r_nx, s_nx} = in_grs;
          if (!in_cout && in_sum == '0 && in_grs == 3'b000) begin
            res_nx   = '0;
            ovf_nx   = 1'b0;
            unf_nx   = 1'b0;
            state_nx = S_DONE;
          end else if (in_cout)        state_nx = S_RSHIFT;
          else if (in_sum[MANT_W-1])   state_nx = S_ROUND;
          else                         state_nx = S_LSHIFT;
        end
      end

      S_RSHIFT: begin
        m_nx = {1'b1, m[MANT_W-1:1]};
        g_nx = m[0];
        r_nx = g;
        s_nx = r | s;
        e_nx = e_inc;
        if (e_inc == EXP_MAX) begin
          res_nx   = inf_res;
          ovf_nx   = 1'b1;
          unf_nx   = 1'b0;
          state_nx = S_DONE;
        end else begin
          state_nx = S_ROUND;
        end
      end

      S_LSHIFT: begin
        if (m[MANT_W-1] || e == '0) begin
          state_nx = S_ROUND;
        end else if (e == EXP_ONE) begin
          e_nx     = '0;
          state_nx = S_ROUND;
        end else begin
          m_nx = {m[MANT_W-2:0], g};
          g_nx = r;
          r_nx = s;
          // Look at the bit that becomes the MSB so the final shift also
          // hands over to ROUND without an extra idle step.
          if (m[MANT_W-2]) begin
            e_nx     = e_dec;
            state_nx = S_ROUND;
          end else if (e_dec <= EXP_ONE) begin
            e_nx     = '0;
            state_nx = S_ROUND;
          end else begin
            e_nx = e_dec;
          end
        end
      end

      S_ROUND: begin
        m_nx     = m_rnd;
        e_nx     = e_rnd;
        res_nx   = rnd_res;
        ovf_nx   = rnd_ovf;
        unf_nx   = rnd_unf;
        state_nx = S_DONE;
      end

      S_DONE: begin
        if (out_ready) state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      sign          <= 1'b0;
      m             <= '0;
      e             <= '0;
      g             <= 1'b0;
      r             <= 1'b0;
      s             <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state         <= state_nx;
      sign          <= sign_nx;
      m             <= m_nx;
      e             <= e_nx;
      g             <= g_nx;
      r             <= r_nx;
      s             <= s_nx;
      out_result    <= res_nx;
      out_overflow  <= ovf_nx;
      out_underflow <= unf_nx;
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// -----------------------------------------------------------------------------
// tb_fp_normalize_round
// Self-checking bench for fp_normalize_round: directed corner cases, a hold
// and a mid-operation reset, then randomized operands compared against an
// arithmetic reference model (result, flags and latency).
// -----------------------------------------------------------------------------
module tb_fp_normalize_round;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_sum;
  logic        in_cout;
  logic [2:0]  in_grs;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;

  int total = 0;
  int bad   = 0;

  fp_normalize_round dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_sum       (in_sum),
    .in_cout      (in_cout),
    .in_grs       (in_grs),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: treat {cout, sum, grs} as a 28-bit integer scaled by 2^(exp),
  // normalize by leading-one position, round the three low bits, then pack.
  function automatic void model(input logic sg, input logic [7:0] ex,
                                input logic [23:0] sm, input logic co,
                                input logic [2:0] gr,
                                output logic [31:0] res, output logic ovf,
                                output logic unf, output int lat);
    logic [27:0] mm;
    logic [23:0] keep;
    logic [24:0] t;
    logic        gg, rs, up;
    int          e, p, k, sh;
    mm = {co, sm, gr};
    e  = int'(ex);
    if (mm == '0) begin
      res = '0; ovf = 1'b0; unf = 1'b0; lat = 1;
      return;
    end
    if (co) begin
      mm = {1'b0, mm[27:2], mm[1] | mm[0]};
      e  = e + 1;
      if (e == 255) begin
        res = {sg, 8'hFF, 23'h0}; ovf = 1'b1; unf = 1'b0; lat = 2;
        return;
      end
      lat = 3;
    end else if (sm[23]) begin
      lat = 2;
    end else begin
      p = 0;
      for (int i = 0; i < 27; i++) if (mm[i]) p = i;
      k = 26 - p;
      if (k <= e - 1) begin
        sh = k;
        e  = e - k;
      end else begin
        sh = (e > 1) ? e - 1 : 0;
        e  = 0;
      end
      // Left shift replicates the sticky bit into the vacated position.
      for (int i = 0; i < sh; i++) mm = {mm[26:0], mm[0]};
      lat = 2 + ((sh > 0) ? sh : 1);
    end
    keep = mm[26:3];
    gg   = mm[2];
    rs   = mm[1] | mm[0];
    up   = gg & (rs | keep[0]);
    t    = {1'b0, keep} + {24'h0, up};
    if (t[24]) begin
      keep = 24'h800000;
      e    = e + 1;
    end else begin
      keep = t[23:0];
    end
    if (e == 0 && keep[23]) e = 1;
    if (e >= 255) begin
      res = {sg, 8'hFF, 23'h0}; ovf = 1'b1; unf = 1'b0;
    end else begin
      res = {sg, 8'(e), keep[22:0]}; ovf = 1'b0; unf = (e == 0);
`ifdef FP_NORM_FLUSH_DENORM_EN
      if (e == 0 && keep[22:0] != 23'h0) res = {sg, 31'h0};
`endif
    end
  endfunction

  // Issue one operation, measure latency, check result/flags, optionally
  // hold out_ready low for `hold` cycles, then complete the handshake.
  task automatic run_op(input string tag, input logic sg, input logic [7:0] ex,
                        input logic [23:0] sm, input logic co, input logic [2:0] gr,
                        input logic [31:0] xres, input logic xovf, input logic xunf,
                        input int xlat, input int hold);
    int n;
    @(negedge clk);
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    in_sign  = sg;
    in_exp   = ex;
    in_sum   = sm;
    in_cout  = co;
    in_grs   = gr;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/latency"},   32'(n), 32'(xlat));
    check({tag, "/result"},    out_result, xres);
    check({tag, "/overflow"},  32'(out_overflow), 32'(xovf));
    check({tag, "/underflow"}, 32'(out_underflow), 32'(xunf));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_valid"},  32'(out_valid), 32'd1);
      check({tag, "/hold_result"}, out_result, xres);
      check({tag, "/hold_ready"},  32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] xres;
    logic        xovf, xunf;
    int          xlat, lz;
    logic [23:0] sm;
    logic [7:0]  ex;
    logic        co, sg;
    logic [2:0]  gr;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_sum    = '0;
    in_cout   = 1'b0;
    in_grs    = '0;
    out_ready = 1'b0;

    #3;
    check("rst/in_ready",  32'(in_ready), 32'd0);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/result",    out_result, 32'h0);
    check("rst/flags",     32'({out_overflow, out_underflow}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst/in_ready", 32'(in_ready), 32'd1);

    // Directed corner cases.
    run_op("normalized", 1'b0, 8'd127, 24'hC00000, 1'b0, 3'b000, 32'h3FC00000, 1'b0, 1'b0, 2, 5);
    run_op("carry_tie",  1'b0, 8'd127, 24'h800001, 1'b1, 3'b000, 32'h40400000, 1'b0, 1'b0, 3, 0);
    run_op("lshift23",   1'b1, 8'd127, 24'h000001, 1'b0, 3'b000, 32'hB4000000, 1'b0, 1'b0, 25, 0);
    run_op("rnd_ovf",    1'b0, 8'd254, 24'hFFFFFF, 1'b0, 3'b100, 32'h7F800000, 1'b1, 1'b0, 2, 0);
`ifdef FP_NORM_FLUSH_DENORM_EN
    run_op("subnormal",  1'b0, 8'd3,   24'h000010, 1'b0, 3'b000, 32'h00000000, 1'b0, 1'b1, 4, 0);
`else
    run_op("subnormal",  1'b0, 8'd3,   24'h000010, 1'b0, 3'b000, 32'h00000040, 1'b0, 1'b1, 4, 0);
`endif
    run_op("zero",       1'b1, 8'd100, 24'h000000, 1'b0, 3'b000, 32'h00000000, 1'b0, 1'b0, 1, 2);
    run_op("rshift_ovf", 1'b0, 8'd254, 24'h800000, 1'b1, 3'b000, 32'h7F800000, 1'b1, 1'b0, 2, 0);
    run_op("tie_up",     1'b0, 8'd127, 24'h800003, 1'b0, 3'b100, 32'h3F800004, 1'b0, 1'b0, 2, 0);
    run_op("tie_down",   1'b0, 8'd127, 24'h800002, 1'b0, 3'b100, 32'h3F800002, 1'b0, 1'b0, 2, 0);

    // Reset in the middle of a long left-shift sequence.
    @(negedge clk);
    in_sign  = 1'b1;
    in_exp   = 8'd127;
    in_sum   = 24'h000001;
    in_cout  = 1'b0;
    in_grs   = 3'b000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst/out_valid", 32'(out_valid), 32'd0);
    check("midrst/in_ready",  32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst/idle",   32'(in_ready), 32'd1);
    check("midrst/result", out_result, 32'h0);
    run_op("after_rst", 1'b0, 8'd127, 24'hC00000, 1'b0, 3'b000, 32'h3FC00000, 1'b0, 1'b0, 2, 0);

    // Randomized operands against the reference model.
    for (int it = 0; it < 250; it++) begin
      sg = 1'($urandom);
      co = ($urandom_range(0, 3) == 0);
      gr = 3'($urandom);
      lz = $urandom_range(0, 24);
      if (lz >= 24) sm = 24'h0;
      else          sm = (24'($urandom) >> lz) | (24'h1 << (23 - lz));
      case ($urandom_range(0, 2))
        0:       ex = 8'($urandom_range(0, 12));
        1:       ex = 8'($urandom_range(240, 254));
        default: ex = 8'($urandom_range(0, 254));
      endcase
      model(sg, ex, sm, co, gr, xres, xovf, xunf, xlat);
      run_op($sformatf("rand%0d", it), sg, ex, sm, co, gr, xres, xovf, xunf, xlat,
             $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
